// File: rtl/risc_spm_mem_responder_if.sv
// CPU-side bus of the RISC_SPM memory responder: request, address/data and
// the one-cycle ready/rdata response.
interface risc_spm_mem_responder_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 8
);
  logic                 req;
  logic                 write;
  logic [ADDR_SIZE-1:0] addr;
  logic [WORD_SIZE-1:0] wdata;
  logic [WORD_SIZE-1:0] rdata;
  logic                 ready;

  modport master (output req, write, addr, wdata, input rdata, ready);
  modport slave  (input req, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/risc_spm_mem_responder.sv
// Memory responder for the RISC_SPM bus: fixed wait-state fetch/load/store
// service, a backdoor preload port, and completed read/write counters.
module risc_spm_mem_responder #(
  parameter int WORD_SIZE   = 8,
  parameter int ADDR_SIZE   = 8,
  parameter int WAIT_STATES = 1,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  risc_spm_mem_responder_if.slave   bus,
  input  logic                      load_en_i,
  input  logic [ADDR_SIZE-1:0]      load_addr_i,
  input  logic [WORD_SIZE-1:0]      load_data_i,
  output logic                      load_err_o,
  output logic [CNT_W-1:0]          rd_count_o,
  output logic [CNT_W-1:0]          wr_count_o
);
  generate
    if (WAIT_STATES > 15 || WAIT_STATES < 0) begin : g_bad_wait_states
      $error("WAIT_STATES must be in the range 0..15");
    end
  endgenerate

  localparam logic [3:0] WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t               state_q, state_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 load_err_q;
  logic [CNT_W-1:0]     rd_count_q, wr_count_q;

  logic [WORD_SIZE-1:0] mem [2**ADDR_SIZE];

  logic                 cpu_wr, preload_ok, mem_we, rd_go;
  logic [ADDR_SIZE-1:0] mem_wa;
  logic [WORD_SIZE-1:0] mem_wd;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addr;
          write_d = bus.write;
          wdata_d = bus.wdata;
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            wcnt_d  = WCNT_INIT;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) state_d = ST_RESP;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The store commits on the edge that leaves RESP; preloads only slip in
  // when the bus is truly idle, so one write port serves both.
  assign cpu_wr     = (state_q == ST_RESP) && write_q;
  assign preload_ok = (state_q == ST_IDLE) && !bus.req && load_en_i;
  assign mem_we     = rst_n && (cpu_wr || preload_ok);
  assign mem_wa     = cpu_wr ? addr_q  : load_addr_i;
  assign mem_wd     = cpu_wr ? wdata_q : load_data_i;
  assign rd_go      = (state_d == ST_RESP) && (state_q != ST_RESP) && !write_d;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      load_err_q <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      load_err_q <= load_en_i && ((state_q != ST_IDLE) || bus.req);
      if (rd_go) rdata_q <= mem[addr_d];
      // Counting on RESP exit means an access aborted by reset is never counted.
      if (state_q == ST_RESP && !write_q) rd_count_q <= rd_count_q + CNT_W'(1);
      if (cpu_wr)                         wr_count_q <= wr_count_q + CNT_W'(1);
    end
  end

  assign bus.ready  = (state_q == ST_RESP);
  assign bus.rdata  = rdata_q;
  assign load_err_o = load_err_q;
  assign rd_count_o = rd_count_q;
  assign wr_count_o = wr_count_q;
endmodule

// File: tb/tb_risc_spm_mem_responder.sv
// Directed bench: three responders (WAIT_STATES 0/1/3, one with a 4-bit
// counter) driven through fetch/load/store, preload and reset scenarios.
module tb_risc_spm_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  risc_spm_mem_responder_if #(.WORD_SIZE(8), .ADDR_SIZE(8)) if0 ();
  risc_spm_mem_responder_if #(.WORD_SIZE(8), .ADDR_SIZE(8)) if1 ();
  risc_spm_mem_responder_if #(.WORD_SIZE(8), .ADDR_SIZE(8)) if3 ();

  logic       ld_en   [4];
  logic [7:0] ld_addr [4];
  logic [7:0] ld_data [4];
  logic       lerr    [4];
  logic [3:0]  rd_cnt0, wr_cnt0;
  logic [15:0] rd_cnt1, wr_cnt1, rd_cnt3, wr_cnt3;

  risc_spm_mem_responder #(.WORD_SIZE(8), .ADDR_SIZE(8), .WAIT_STATES(0), .CNT_W(4)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .bus(if0),
    .load_en_i(ld_en[0]), .load_addr_i(ld_addr[0]), .load_data_i(ld_data[0]),
    .load_err_o(lerr[0]), .rd_count_o(rd_cnt0), .wr_count_o(wr_cnt0));

  risc_spm_mem_responder #(.WORD_SIZE(8), .ADDR_SIZE(8), .WAIT_STATES(1), .CNT_W(16)) u_ws1 (
    .clk(clk), .rst_n(rst_n), .bus(if1),
    .load_en_i(ld_en[1]), .load_addr_i(ld_addr[1]), .load_data_i(ld_data[1]),
    .load_err_o(lerr[1]), .rd_count_o(rd_cnt1), .wr_count_o(wr_cnt1));

  risc_spm_mem_responder #(.WORD_SIZE(8), .ADDR_SIZE(8), .WAIT_STATES(3), .CNT_W(16)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .bus(if3),
    .load_en_i(ld_en[3]), .load_addr_i(ld_addr[3]), .load_data_i(ld_data[3]),
    .load_err_o(lerr[3]), .rd_count_o(rd_cnt3), .wr_count_o(wr_cnt3));

  int nvec = 0;
  int nerr = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s: observed %0h expected %0h", nvec, tag, obs, exp);
  endtask

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
    case (sel)
      0: begin if0.req = r; if0.write = w; if0.addr = a; if0.wdata = d; end
      1: begin if1.req = r; if1.write = w; if1.addr = a; if1.wdata = d; end
      3: begin if3.req = r; if3.write = w; if3.addr = a; if3.wdata = d; end
      default: ;
    endcase
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0: return if0.ready;
      1: return if1.ready;
      3: return if3.ready;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] rdat(input int sel);
    case (sel)
      0: return if0.rdata;
      1: return if1.rdata;
      3: return if3.rdata;
      default: return 8'h00;
    endcase
  endfunction

  task automatic preload(input int sel, input logic [7:0] a, input logic [7:0] d);
    ld_en[sel] = 1'b1; ld_addr[sel] = a; ld_data[sel] = d;
    tick();
    ld_en[sel] = 1'b0;
  endtask

  // One access; lat = edges from driving req until ready is seen (bounded).
  task automatic acc(input int sel, input logic w, input logic [7:0] a, input logic [7:0] d,
                     output int lat, output logic [7:0] rd);
    drive(sel, 1'b1, w, a, d);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!rdy(sel) && lat < 40);
    rd = rdat(sel);
    drive(sel, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  int         lat;
  logic [7:0] rd;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_en[i] = 1'b0; ld_addr[i] = 8'h00; ld_data[i] = 8'h00;
    end
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); drive(3, 0, 0, 0, 0);
    tick(); tick();

    chk("reset_ready",    32'(if1.ready), 32'h0);
    chk("reset_load_err", 32'(lerr[1]),   32'h0);
    chk("reset_rdata",    32'(if1.rdata), 32'h0);
    chk("reset_rd_count", 32'(rd_cnt1),   32'h0);
    chk("reset_wr_count", 32'(wr_cnt1),   32'h0);
    rst_n = 1'b1;
    tick();

    // Preload then read with one wait state
    preload(1, 8'h10, 8'hA5);
    chk("preload_no_err", 32'(lerr[1]), 32'h0);
    acc(1, 1'b0, 8'h10, 8'h00, lat, rd);
    chk("ws1_read_latency", 32'(lat), 32'd2);
    chk("ws1_read_data",    32'(rd),  32'hA5);
    chk("ws1_rd_count",     32'(rd_cnt1), 32'd1);
    chk("ws1_ready_pulse",  32'(if1.ready), 32'h0);

    // Back-to-back store then load to the same address
    drive(1, 1'b1, 1'b1, 8'h20, 8'h3C);
    lat = 0;
    do begin tick(); lat++; end while (!if1.ready && lat < 40);
    chk("b2b_write_latency", 32'(lat), 32'd2);
    drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
    lat = 0;
    do begin tick(); lat++; end while (!if1.ready && lat < 40);
    chk("b2b_spacing",   32'(lat),      32'd3);
    chk("b2b_read_data", 32'(if1.rdata), 32'h3C);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("b2b_wr_count", 32'(wr_cnt1), 32'd1);
    chk("b2b_rd_count", 32'(rd_cnt1), 32'd2);

    // Bus changes after acceptance are ignored
    drive(1, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    drive(1, 1'b1, 1'b1, 8'h20, 8'hFF);
    tick();
    chk("ignore_ready", 32'(if1.ready), 32'h1);
    chk("ignore_rdata", 32'(if1.rdata), 32'hA5);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    acc(1, 1'b0, 8'h20, 8'h00, lat, rd);
    chk("ignore_no_write", 32'(rd), 32'h3C);

    // Zero and three wait states
    preload(0, 8'h00, 8'hC3);
    acc(0, 1'b0, 8'h00, 8'h00, lat, rd);
    chk("ws0_latency", 32'(lat), 32'd1);
    chk("ws0_data",    32'(rd),  32'hC3);
    preload(3, 8'h00, 8'h5A);
    acc(3, 1'b0, 8'h00, 8'h00, lat, rd);
    chk("ws3_latency", 32'(lat), 32'd4);
    chk("ws3_data",    32'(rd),  32'h5A);

    // Preload during WAIT is dropped
    preload(1, 8'h40, 8'h11);
    preload(1, 8'h50, 8'h22);
    drive(1, 1'b1, 1'b0, 8'h40, 8'h00);
    tick();
    ld_en[1] = 1'b1; ld_addr[1] = 8'h40; ld_data[1] = 8'hEE;
    tick();
    chk("wait_load_err",   32'(lerr[1]),   32'h1);
    chk("wait_load_ready", 32'(if1.ready), 32'h1);
    ld_en[1] = 1'b0;
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk("load_err_one_cycle", 32'(lerr[1]), 32'h0);

    // Preload in the same cycle a request is accepted is dropped
    drive(1, 1'b1, 1'b0, 8'h50, 8'h00);
    ld_en[1] = 1'b1; ld_addr[1] = 8'h50; ld_data[1] = 8'h99;
    tick();
    chk("accept_load_err", 32'(lerr[1]), 32'h1);
    ld_en[1] = 1'b0;
    tick();
    chk("accept_ready", 32'(if1.ready), 32'h1);
    chk("accept_rdata", 32'(if1.rdata), 32'h22);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    acc(1, 1'b0, 8'h40, 8'h00, lat, rd);
    chk("wait_load_target_kept", 32'(rd), 32'h11);

    // Reset in the middle of a store's wait state
    preload(1, 8'h30, 8'h77);
    drive(1, 1'b1, 1'b1, 8'h30, 8'h88);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_abort_ready",    32'(if1.ready), 32'h0);
    chk("rst_abort_rd_count", 32'(rd_cnt1),   32'h0);
    chk("rst_abort_wr_count", 32'(wr_cnt1),   32'h0);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_after_ready", 32'(if1.ready), 32'h0);
    acc(1, 1'b0, 8'h30, 8'h00, lat, rd);
    chk("rst_mem_kept",     32'(rd),      32'h77);
    chk("rst_read_latency", 32'(lat),     32'd2);
    chk("rst_wr_count",     32'(wr_cnt1), 32'h0);

    // 4-bit counter wraps after 17 reads
    for (int i = 0; i < 17; i++) acc(0, 1'b0, 8'h00, 8'h00, lat, rd);
    chk("wrap_rd_count", 32'(rd_cnt0), 32'd1);
    chk("wrap_wr_count", 32'(wr_cnt0), 32'd0);
    chk("wrap_last_data", 32'(rd),     32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
